// File: rtl/trng_health_pkg.sv
// trng_health_pkg: shared state type and counter-width helper for the TRNG health monitor
package trng_health_pkg;
  typedef enum logic [1:0] {STARTUP, RUN, ALARM} health_state_e;
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/apt_window_counter.sv
// apt_window_counter: adaptive proportion test window with reference capture and match count
module apt_window_counter
  import trng_health_pkg::*;
#(
  parameter int APT_WINDOW = 1024,
  parameter int APT_CUTOFF = 600
) (
  input  logic clk,
  input  logic rst_i,
  input  logic clr_i,
  input  logic bit_i,
  input  logic valid_i,
  output logic window_done_o,
  output logic window_fail_o
);
  localparam int CW = cnt_w(APT_WINDOW);
  logic ref_q, ref_d;
  logic [CW-1:0] cnt_q, cnt_d, idx_q, idx_d, cnt_m;
  logic first_s, last_s;
  always_comb begin
    first_s = idx_q == '0;
    last_s = idx_q == CW'(APT_WINDOW - 1);
    cnt_m = cnt_q + CW'(bit_i == ref_q);
    window_done_o = valid_i && !clr_i && last_s;
    window_fail_o = window_done_o && cnt_m >= CW'(APT_CUTOFF);
    ref_d = valid_i && first_s ? bit_i : ref_q;
    cnt_d = clr_i || window_done_o ? '0 : !valid_i ? cnt_q : first_s ? CW'(1) : cnt_m;
    idx_d = clr_i || window_done_o ? '0 : valid_i ? idx_q + CW'(1) : idx_q;
  end
  always_ff @(posedge clk) begin
    if (rst_i) begin
      ref_q <= 1'b0;
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      ref_q <= ref_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end
endmodule

// File: rtl/trng_health_monitor.sv
// trng_health_monitor: RCT/APT health tests with startup qualification and sticky alarm
module trng_health_monitor
  import trng_health_pkg::*;
#(
  parameter int RCT_CUTOFF      = 32,
  parameter int APT_WINDOW      = 1024,
  parameter int APT_CUTOFF      = 600,
  parameter int STARTUP_WINDOWS = 1,
  parameter int FAIL_THRESH     = 4
) (
  input  logic                               clk,
  input  logic                               rst_i,
  input  logic                               rnd_bit_i,
  input  logic                               bit_valid_i,
  input  logic                               alarm_clr_i,
  output logic                               rct_fail_o,
  output logic                               apt_fail_o,
  output logic                               window_done_o,
  output logic                               error_o,
  output logic                               startup_done_o,
  output logic                               alarm_o,
  output logic [$clog2(FAIL_THRESH+1)-1:0]   fail_cnt_o
);
  localparam int RW = cnt_w(RCT_CUTOFF);
  localparam int FW = cnt_w(FAIL_THRESH);
  localparam int SW = cnt_w(STARTUP_WINDOWS);
  health_state_e state_q, state_d;
  logic [RW-1:0] run_q, run_d;
  logic [FW-1:0] fail_q, fail_d, fail_sat;
  logic [SW-1:0] clean_q, clean_d;
  logic [FW:0] fail_sum;
  logic [1:0] n_ev;
  logic last_q, last_d, rct_win_q, rct_win_d;
  logic clr, take, rct_ev, win_done, win_fail, clean;
  logic rct_fail_q, apt_fail_q, done_q, run_st_q, alarm_q;
  apt_window_counter #(
    .APT_WINDOW(APT_WINDOW),
    .APT_CUTOFF(APT_CUTOFF)
  ) u_apt (
    .clk          (clk),
    .rst_i        (rst_i),
    .clr_i        (clr),
    .bit_i        (rnd_bit_i),
    .valid_i      (bit_valid_i),
    .window_done_o(win_done),
    .window_fail_o(win_fail)
  );
  always_comb begin
    clr = alarm_clr_i && state_q == ALARM;
    take = bit_valid_i && !clr;
    run_d = clr ? '0 : !take ? run_q : (run_q == '0 || rnd_bit_i != last_q) ? RW'(1) :
            run_q == RW'(RCT_CUTOFF) ? run_q : run_q + RW'(1);
    last_d = take ? rnd_bit_i : last_q;
    rct_ev = take && run_d == RW'(RCT_CUTOFF) && run_q != RW'(RCT_CUTOFF);
    rct_win_d = clr || win_done ? 1'b0 : rct_win_q | rct_ev;
    clean = win_done && !win_fail && !rct_win_q && !rct_ev;
    n_ev = {1'b0, rct_ev} + {1'b0, win_fail};
    fail_sum = (FW+1)'(fail_q) + (FW+1)'(n_ev);
    fail_sat = fail_sum >= (FW+1)'(FAIL_THRESH) ? FW'(FAIL_THRESH) : fail_sum[FW-1:0];
    state_d = state_q;
    fail_d = fail_q;
    clean_d = clean_q;
    if (clr) begin
      state_d = STARTUP;
      fail_d = '0;
      clean_d = '0;
    end else if (n_ev != 2'd0) begin
      fail_d = fail_sat;
      clean_d = state_q == STARTUP ? '0 : clean_q;
      state_d = fail_sat == FW'(FAIL_THRESH) ? ALARM : state_q;
    end else if (clean && state_q == RUN) begin
      fail_d = '0;
    end else if (clean && state_q == STARTUP) begin
      state_d = clean_q == SW'(STARTUP_WINDOWS - 1) ? RUN : STARTUP;
      fail_d = clean_q == SW'(STARTUP_WINDOWS - 1) ? '0 : fail_q;
      clean_d = clean_q == SW'(STARTUP_WINDOWS - 1) ? '0 : clean_q + SW'(1);
    end
  end
  always_ff @(posedge clk) begin
    if (rst_i) begin
      state_q <= STARTUP;
      run_q <= '0;
      last_q <= 1'b0;
      rct_win_q <= 1'b0;
      fail_q <= '0;
      clean_q <= '0;
      rct_fail_q <= 1'b0;
      apt_fail_q <= 1'b0;
      done_q <= 1'b0;
      run_st_q <= 1'b0;
      alarm_q <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q <= run_d;
      last_q <= last_d;
      rct_win_q <= rct_win_d;
      fail_q <= fail_d;
      clean_q <= clean_d;
      rct_fail_q <= run_d == RW'(RCT_CUTOFF);
      apt_fail_q <= win_fail;
      done_q <= win_done;
      run_st_q <= state_d == RUN;
      alarm_q <= state_d == ALARM;
    end
  end
  assign rct_fail_o = rct_fail_q;
  assign apt_fail_o = apt_fail_q;
  assign window_done_o = done_q;
  assign error_o = rct_fail_q | apt_fail_q;
  assign startup_done_o = run_st_q;
  assign alarm_o = alarm_q;
  assign fail_cnt_o = fail_q;
endmodule

// File: tb/tb_trng_health_monitor.sv
// tb_trng_health_monitor: directed and randomized checks against a behavioural health-test model
module tb_trng_health_monitor;
  localparam int RC = 8;
  localparam int AW = 16;
  localparam int AC = 13;
  localparam int SW = 2;
  localparam int FT = 3;
  logic clk = 1'b0;
  logic rst = 1'b0, rnd_bit = 1'b0, bit_valid = 1'b0, alarm_clr = 1'b0;
  logic rct_fail, apt_fail, window_done, error, startup_done, alarm;
  logic [1:0] fail_cnt;
  int tests = 0, fails = 0;
  int m_state = 0, m_fail = 0, m_clean = 0;
  bit m_rct_win = 0, e_rct = 0, e_apt = 0, e_done = 0;
  bit hist[$];
  bit win[$];
  logic rv, rb, rcl, rr, prev, tog;
  int rep;
  trng_health_monitor #(
    .RCT_CUTOFF(RC),
    .APT_WINDOW(AW),
    .APT_CUTOFF(AC),
    .STARTUP_WINDOWS(SW),
    .FAIL_THRESH(FT)
  ) dut (
    .clk           (clk),
    .rst_i         (rst),
    .rnd_bit_i     (rnd_bit),
    .bit_valid_i   (bit_valid),
    .alarm_clr_i   (alarm_clr),
    .rct_fail_o    (rct_fail),
    .apt_fail_o    (apt_fail),
    .window_done_o (window_done),
    .error_o       (error),
    .startup_done_o(startup_done),
    .alarm_o       (alarm),
    .fail_cnt_o    (fail_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_state = 0;
    m_fail = 0;
    m_clean = 0;
    m_rct_win = 0;
    hist.delete();
    win.delete();
    e_rct = 0;
    e_apt = 0;
    e_done = 0;
  endtask
  task automatic model_step(input logic v, input logic b, input logic c);
    int run, match, nev;
    bit rev, aev, clean;
    e_apt = 0;
    e_done = 0;
    if (c && m_state == 2) begin
      model_reset();
      return;
    end
    if (!v) return;
    hist.push_back(b);
    if (hist.size() > RC + 1) void'(hist.pop_front());
    run = 0;
    for (int i = hist.size() - 1; i >= 0 && hist[i] == b; i--) run++;
    rev = run == RC;
    e_rct = run >= RC;
    if (rev) m_rct_win = 1;
    win.push_back(b);
    aev = 0;
    clean = 0;
    if (win.size() == AW) begin
      match = 0;
      foreach (win[i]) if (win[i] == win[0]) match++;
      aev = match >= AC;
      clean = !aev && !m_rct_win;
      e_done = 1;
      e_apt = aev;
      m_rct_win = 0;
      win.delete();
    end
    nev = int'(rev) + int'(aev);
    if (nev > 0) begin
      m_fail = (m_fail + nev > FT) ? FT : m_fail + nev;
      if (m_state == 0) m_clean = 0;
      if (m_fail == FT) m_state = 2;
    end else if (clean && m_state == 1) begin
      m_fail = 0;
    end else if (clean && m_state == 0) begin
      m_clean++;
      if (m_clean == SW) begin
        m_state = 1;
        m_fail = 0;
        m_clean = 0;
      end
    end
  endtask
  task automatic step(input logic v, input logic b, input logic c, input logic r);
    bit_valid = v;
    rnd_bit = b;
    alarm_clr = c;
    rst = r;
    @(posedge clk);
    if (r) model_reset();
    else model_step(v, b, c);
    #1;
    chk("rct_fail", rct_fail, e_rct);
    chk("apt_fail", apt_fail, e_apt);
    chk("window_done", window_done, e_done);
    chk("error", error, e_rct | e_apt);
    chk("startup_done", startup_done, m_state == 1);
    chk("alarm", alarm, m_state == 2);
    chk("fail_cnt", fail_cnt, m_fail);
  endtask
  task automatic send(input int n, input logic b);
    for (int i = 0; i < n; i++) step(1'b1, b, 1'b0, 1'b0);
  endtask
  task automatic alt(input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps) step(1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b1, i[0], 1'b0, 1'b0);
    end
  endtask
  task automatic fill_window();
    tog = 1'b0;
    while (win.size() != 0) begin
      step(1'b1, tog, 1'b0, 1'b0);
      tog = ~tog;
    end
  endtask
  initial begin
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("reset_state", {startup_done, alarm, fail_cnt}, 0);
    alt(32, 0);
    chk("startup_after_32", startup_done, 1);
    send(1, 0);
    send(8, 1);
    chk("rct_level", rct_fail, 1);
    chk("rct_fail_cnt", fail_cnt, 1);
    send(1, 1);
    chk("rct_no_second", fail_cnt, 1);
    send(1, 0);
    chk("rct_drop", rct_fail, 0);
    fill_window();
    send(6, 1); send(1, 0); send(5, 1); send(1, 0); send(1, 1); send(1, 0); send(1, 1);
    chk("apt_pulse", {apt_fail, window_done}, 2'b11);
    chk("apt_fail_cnt", fail_cnt, 2);
    alt(16, 0);
    chk("clean_zeroes_cnt", fail_cnt, 0);
    send(16, 0);
    chk("dual_event_cnt", fail_cnt, 2);
    send(16, 0);
    chk("alarm_raised", alarm, 1);
    send(10, 0);
    chk("alarm_sticky", {alarm, fail_cnt}, {1'b1, 2'd3});
    step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("clear_to_startup", {alarm, startup_done, fail_cnt}, 0);
    alt(32, 0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    chk("clr_ignored_in_run", startup_done, 1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    alt(10, 1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("mid_window_reset", {rct_fail, apt_fail, window_done, startup_done, alarm, fail_cnt}, 0);
    alt(32, 1);
    chk("gapped_startup", startup_done, 1);
    prev = 1'b0;
    for (int s = 0; s < 8; s++) begin
      rep = $urandom_range(40, 97);
      for (int i = 0; i < 150; i++) begin
        rv = $urandom_range(0, 3) != 0;
        rb = ($urandom_range(0, 99) < rep) ? prev : ~prev;
        rcl = $urandom_range(0, 15) == 0;
        rr = $urandom_range(0, 399) == 0;
        step(rv, rb, rcl, rr);
        if (rv) prev = rb;
      end
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/trng_health_monitor.md
# trng_health_monitor

Parametrised continuous health monitor for the single-bit TRNG raw stream. It implements a true run-length Repetition Count Test (RCT) and a windowed Adaptive Proportion Test (APT) with configurable cutoffs. A startup qualification phase and a sticky, software-clearable alarm driven by a failure-event counter sit on top of both tests. It sits between the entropy source sampler and the conditioner; downstream logic consumes bits only while `startup_done_o` is high and `alarm_o` is low.

## Interface
- `RCT_CUTOFF`, 32: run length of identical bits that constitutes an RCT failure; ≥2.
- `APT_WINDOW`, 1024: samples per APT window; ≥2.
- `APT_CUTOFF`, 600: matches-to-reference count (reference sample included) that fails a window; ≤`APT_WINDOW`.
- `STARTUP_WINDOWS`, 1: consecutive clean APT windows required to leave startup; ≥1.
- `FAIL_THRESH`, 4: failure events without an intervening clean window that raise the alarm; ≥1.
- `clk` in 1: clock.
- `rst_i` in 1: synchronous reset, active-high.
- `rnd_bit_i` in 1: raw sample.
- `bit_valid_i` in 1: sample qualifier; a sample is consumed only on cycles where it is high.
- `alarm_clr_i` in 1: clears alarm; honoured only in ALARM state.
- `rct_fail_o` out 1: level; run length ≥ `RCT_CUTOFF`.
- `apt_fail_o` out 1: one-cycle pulse; the window just closed failed.
- `window_done_o` out 1: one-cycle pulse at every window close.
- `error_o` out 1: `rct_fail_o | apt_fail_o`.
- `startup_done_o` out 1: high in RUN state.
- `alarm_o` out 1: high in ALARM state.
- `fail_cnt_o` out `$clog2(FAIL_THRESH+1)`: current failure-event count.

## Operation
- RCT:
  - First sample after reset or clear gives `run_len`=1 and `last_bit`=sample.
  - Later samples: equal to `last_bit` → `run_len` increments, saturating at `RCT_CUTOFF`; different → `run_len`=1.
  - RCT event: the single sample on which `run_len` becomes `RCT_CUTOFF`. No further events until the run breaks.
- APT:
  - The first sample of a window is the reference; count=1.
  - Each following sample adds 1 if equal to the reference.
  - On sample number `APT_WINDOW`, the final count (including that sample) ≥ `APT_CUTOFF` → APT failure event; otherwise the window passes.
  - The next valid sample opens a new window.
- Clean window: a passing APT window during which no RCT event occurred.
- FSM states: STARTUP (reset state), RUN, ALARM. Tests run in all states.
- STARTUP:
  - Any failure event zeroes the clean-window counter and increments `fail_cnt`.
  - `STARTUP_WINDOWS` consecutive clean windows → RUN and `fail_cnt`=0.
- RUN:
  - Each failure event increments `fail_cnt`.
  - A clean window zeroes `fail_cnt`.
- From STARTUP or RUN, `fail_cnt` reaching `FAIL_THRESH` → ALARM.
- ALARM:
  - State is sticky; `fail_cnt` saturates at `FAIL_THRESH`.
  - `alarm_clr_i` → STARTUP, clearing the RCT, APT, clean-window and fail counters.
- Simultaneous events: an RCT event and an APT failure on the same sample add 2, saturating. An RCT event coinciding with a passing window close makes that window not clean.
- Width rules:
  - `run_len`: `$clog2(RCT_CUTOFF+1)` bits.
  - APT count and index: `$clog2(APT_WINDOW+1)` bits.
  - No counter may wrap.

## Timing
- All outputs are registered, except `error_o`, which is combinational from registered outputs.
- Reset values: every output 0; state STARTUP; all counters 0.
- Latency: a sample consumed in cycle N updates `rct_fail_o`, `apt_fail_o`, `window_done_o`, `fail_cnt_o` and the state in cycle N+1.
- Pulses last exactly one cycle, even if `bit_valid_i` is low afterwards.
- `bit_valid_i` low: all state is held and no pulses occur.
- `alarm_clr_i` and a valid sample in the same cycle: the clear wins and the sample is discarded.
- `rst_i` mid-window or mid-run: everything returns to reset values on the next edge; partial counts are lost.

## Structure
- Package `trng_health_pkg`:
  - `health_state_e` enum (STARTUP, RUN, ALARM).
  - Width helper constants.
- Sub-module `apt_window_counter`:
  - Reference capture, match count and sample index.
  - Outputs `window_done` and `window_fail` pulses.
- RCT logic and the FSM live in the top module.

## Test plan
Bench parameters: RCT_CUTOFF=8, APT_WINDOW=16, APT_CUTOFF=13, STARTUP_WINDOWS=2, FAIL_THRESH=3.
- Reset, then alternating 0101… for 32 valid samples → two clean windows; `startup_done_o`=1 the cycle after sample 32; `error_o` never high.
- In RUN, 8 consecutive ones → `rct_fail_o` rises the cycle after the 8th; `fail_cnt_o`=1; a 9th one gives no second event; a 0 drops `rct_fail_o`.
- In RUN, a window with 13 matches and no run ≥8 → `apt_fail_o` pulses once with `window_done_o`; `fail_cnt_o` increments; next clean window → `fail_cnt_o`=0.
- All-zero stream for 16 samples → RCT event at sample 8 plus APT failure at sample 16; `fail_cnt_o`=2; stream continues to the next window failure → `alarm_o`=1; further samples keep `alarm_o`=1.
- `alarm_clr_i` pulsed together with a valid sample → sample ignored, state STARTUP, counters 0; `alarm_clr_i` in RUN has no effect.
- `bit_valid_i` toggled every other cycle during the first scenario → identical results to the first scenario, with each window's completion delayed to its 16th valid sample; `rst_i` asserted at sample 10 → all outputs 0 next cycle.
